ddr_channel_arb: RTL



---
 rtl/ddr_channel_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ddr_channel_arb.sv
// Round-robin arbiter for the pc fetch, lw load and sw store channels onto the
// single-port DDR request interface. One operation in flight; responses are registered.
module ddr_channel_arb #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_index_valid,
  input  logic [ADDR_W-1:0] pc_index,
  output logic              pc_index_ready,
  input  logic              pc_flush,
  output logic              pc_operation_done,
  output logic [LINE_W-1:0] pc_read_inst,
  input  logic              lw_valid,
  input  logic [ADDR_W-1:0] lw_index,
  output logic              lw_ready,
  output logic              lw_operation_done,
  output logic [LINE_W-1:0] lw_read_data,
  input  logic              sw_valid,
  input  logic [ADDR_W-1:0] sw_index,
  input  logic [LINE_W-1:0] sw_write_data,
  output logic              sw_ready,
  output logic              sw_operation_done,
  output logic              ddr_chip_enable,
  output logic [ADDR_W-1:0] ddr_index,
  output logic              ddr_write_enable,
  output logic              ddr_burst_mode,
  output logic [LINE_W-1:0] ddr_write_data,
  input  logic [LINE_W-1:0] ddr_read_data,
  input  logic              ddr_operation_done,
  input  logic              ddr_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] CH_PC   = 2'd0;
  localparam logic [1:0] CH_LW   = 2'd1;
  localparam logic [1:0] CH_SW   = 2'd2;
  localparam logic [1:0] CH_NONE = 2'd3;

  state_e              state_q;
  logic [1:0]          last_q, gnt_q;
  logic                kill_q;
  logic                ce_q, we_q, burst_q;
  logic [ADDR_W-1:0]   index_q;
  logic [LINE_W-1:0]   wdata_q, pc_inst_q, lw_data_q;
  logic                pc_done_q, lw_done_q, sw_done_q;

  logic [1:0]          gnt_ch;
  logic                gnt_vld;
  logic                pc_busy, kill_now;

  // Scan starts just after the last granted channel, so it becomes lowest priority.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] c;
    rr_pick = CH_NONE;
    c = last;
    for (int i = 0; i < 3; i++) begin
      c = (c == CH_SW) ? CH_PC : c + 2'd1;
      if (rr_pick == CH_NONE && req[c]) rr_pick = c;
    end
  endfunction

  always_comb begin
    gnt_ch  = CH_NONE;
    gnt_vld = 1'b0;
    if (state_q == S_IDLE && ddr_ready) begin
      gnt_ch  = rr_pick({sw_valid, lw_valid, pc_index_valid}, last_q);
      gnt_vld = (gnt_ch != CH_NONE);
    end
  end

  assign pc_index_ready = gnt_vld && gnt_ch == CH_PC;
  assign lw_ready       = gnt_vld && gnt_ch == CH_LW;
  assign sw_ready       = gnt_vld && gnt_ch == CH_SW;

  assign pc_busy  = (state_q == S_ISSUE || state_q == S_WAIT) && gnt_q == CH_PC;
  assign kill_now = kill_q || (pc_busy && pc_flush);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      last_q    <= CH_SW;
      gnt_q     <= CH_PC;
      kill_q    <= 1'b0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      burst_q   <= 1'b0;
      index_q   <= '0;
      wdata_q   <= '0;
      pc_inst_q <= '0;
      lw_data_q <= '0;
      pc_done_q <= 1'b0;
      lw_done_q <= 1'b0;
      sw_done_q <= 1'b0;
    end else begin
      ce_q      <= 1'b0;
      pc_done_q <= 1'b0;
      lw_done_q <= 1'b0;
      sw_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          kill_q <= 1'b0;
          if (gnt_vld) begin
            gnt_q   <= gnt_ch;
            last_q  <= gnt_ch;
            ce_q    <= 1'b1;
            we_q    <= (gnt_ch == CH_SW);
            burst_q <= (gnt_ch == CH_PC);
            kill_q  <= (gnt_ch == CH_PC) && pc_flush;
            case (gnt_ch)
              CH_PC:   begin index_q <= pc_index; wdata_q <= '0; end
              CH_LW:   begin index_q <= lw_index; wdata_q <= '0; end
              default: begin index_q <= sw_index; wdata_q <= sw_write_data; end
            endcase
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          kill_q  <= kill_now;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          kill_q <= kill_now;
          if (ddr_operation_done) begin
            case (gnt_q)
              CH_PC: if (!kill_now) begin
                pc_inst_q <= ddr_read_data;
                pc_done_q <= 1'b1;
              end
              CH_LW: begin
                lw_data_q <= ddr_read_data;
                lw_done_q <= 1'b1;
              end
              default: sw_done_q <= 1'b1;
            endcase
            state_q <= S_RESP;
          end
        end
        default: begin
          kill_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ddr_chip_enable   = ce_q;
  assign ddr_index         = index_q;
  assign ddr_write_enable  = we_q;
  assign ddr_burst_mode    = burst_q;
  assign ddr_write_data    = wdata_q;
  assign pc_operation_done = pc_done_q;
  assign pc_read_inst      = pc_inst_q;
  assign lw_operation_done = lw_done_q;
  assign lw_read_data      = lw_data_q;
  assign sw_operation_done = sw_done_q;

endmodule
